// File: rtl/cpu_control_unit_pkg.sv
// Shared definitions for the CPU control unit: FSM state encoding, op-codes
// and instruction field positions derived from the register-address width.
package cpu_control_unit_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ARM_USER,
        ARM_RUN,
        FETCH,
        LATCH_USER,
        LOAD,
        STORE,
        MOVE,
        ALU_IN,
        ALU_EXEC,
        ALU_OUT,
        RETIRE,
        PAUSE
    } state_t;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_LOAD  = 2'b00;
    localparam logic [OP_W-1:0] OP_STORE = 2'b01;
    localparam logic [OP_W-1:0] OP_MOVE  = 2'b10;
    localparam logic [OP_W-1:0] OP_ALU   = 2'b11;

    // Instruction layout, MSB to LSB: op | dst | src | func
    function automatic int instr_width(input int ra_w);
        return OP_W + 3 * ra_w;
    endfunction

    function automatic int op_lsb(input int ra_w);
        return 3 * ra_w;
    endfunction

    function automatic int dst_lsb(input int ra_w);
        return 2 * ra_w;
    endfunction

    function automatic int src_lsb(input int ra_w);
        return ra_w;
    endfunction

    function automatic int func_lsb(input int ra_w);
        return 0 * ra_w;
    endfunction

    function automatic state_t decode_op(input logic [OP_W-1:0] op);
        state_t s;
        case (op)
            OP_LOAD:  s = LOAD;
            OP_STORE: s = STORE;
            OP_MOVE:  s = MOVE;
            default:  s = ALU_IN;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cpu_control_unit_sel.sv
// One-hot register select decoder with enable; used for both the bus-drive
// and bus-load register strobes.
module reg_sel_decoder #(
    parameter  int RA_W = 2,
    localparam int NREG = 2 ** RA_W
) (
    input  logic [RA_W-1:0] addr,
    input  logic            en,
    output logic [NREG-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Microsequencer for a small bus-based CPU: fetches or accepts a user
// instruction, steps it through bus-transfer states and sequences the run.
module cpu_control_unit
    import cpu_control_unit_pkg::*;
#(
    parameter  int              RA_W     = 2,
    parameter  int              PC_W     = 10,
    parameter  logic [PC_W-1:0] PROG_END = '1,
    localparam int              NREG     = 2 ** RA_W,
    localparam int              INSTR_W  = 2 + 3 * RA_W
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 user_btn,
    input  logic                 run_btn,
    input  logic                 step_mode,
    input  logic [INSTR_W-1:0]   instr_user,
    input  logic [INSTR_W-1:0]   instr_mem,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic [PC_W-1:0]      pc,
    output logic [RA_W-1:0]      alu_op,
    output logic [NREG-1:0]      reg_oe,
    output logic [NREG-1:0]      reg_we,
    output logic                 alu_a_we,
    output logic                 alu_b_we,
    output logic                 alu_oe,
    output logic                 imm_oe,
    output logic                 mem_we,
    output logic [2*RA_W-1:0]    instr_bus,
    output logic                 busy,
    output logic                 paused,
    output logic                 regs_clr
);

    localparam int OP_LSB   = op_lsb(RA_W);
    localparam int DST_LSB  = dst_lsb(RA_W);
    localparam int SRC_LSB  = src_lsb(RA_W);
    localparam int FUNC_LSB = func_lsb(RA_W);

    state_t              state;
    state_t              nxt_state;
    logic [INSTR_W-1:0]  ir;
    logic [INSTR_W-1:0]  nxt_ir;
    logic [PC_W-1:0]     nxt_pc;
    logic                run_prev;

    logic                oe_en;
    logic [RA_W-1:0]     oe_addr;
    logic                we_en;
    logic [RA_W-1:0]     we_addr;

    logic [RA_W-1:0]     nxt_dst;
    logic [RA_W-1:0]     nxt_src;
    logic [RA_W-1:0]     nxt_func;

    assign nxt_dst  = nxt_ir[DST_LSB  +: RA_W];
    assign nxt_src  = nxt_ir[SRC_LSB  +: RA_W];
    assign nxt_func = nxt_ir[FUNC_LSB +: RA_W];

    always_comb begin
        nxt_state = state;
        nxt_ir    = ir;
        nxt_pc    = pc;
        case (state)
            IDLE: begin
                if (user_btn) begin
                    nxt_state = ARM_USER;
                    nxt_pc    = PROG_END;
                end else if (run_btn) begin
                    nxt_state = ARM_RUN;
                    nxt_pc    = '0;
                end
            end
            ARM_USER: if (!user_btn) nxt_state = LATCH_USER;
            ARM_RUN:  if (!run_btn)  nxt_state = FETCH;
            FETCH: begin
                if (mem_ack) begin
                    nxt_ir    = instr_mem;
                    nxt_state = decode_op(instr_mem[OP_LSB +: OP_W]);
                end
            end
            LATCH_USER: begin
                nxt_ir    = instr_user;
                nxt_state = decode_op(instr_user[OP_LSB +: OP_W]);
            end
            LOAD, STORE, MOVE, ALU_OUT: nxt_state = RETIRE;
            ALU_IN:   nxt_state = ALU_EXEC;
            ALU_EXEC: nxt_state = ALU_OUT;
            RETIRE: begin
                // PROG_END doubles as the user-mode marker, so user mode stops here too
                if (pc >= PROG_END) begin
                    nxt_state = IDLE;
                end else begin
                    nxt_pc    = pc + PC_W'(1);
                    nxt_state = step_mode ? PAUSE : FETCH;
                end
            end
            PAUSE: if (run_btn && !run_prev) nxt_state = FETCH;
            default: nxt_state = IDLE;
        endcase
    end

    // Strobes are registered from the state being entered so they line up with it
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            ir       <= '0;
            pc       <= '0;
            run_prev <= 1'b0;
            mem_req  <= 1'b0;
            imm_oe   <= 1'b0;
            alu_oe   <= 1'b0;
            alu_a_we <= 1'b0;
            alu_b_we <= 1'b0;
            mem_we   <= 1'b0;
            alu_op   <= '0;
            oe_en    <= 1'b0;
            oe_addr  <= '0;
            we_en    <= 1'b0;
            we_addr  <= '0;
        end else begin
            state    <= nxt_state;
            ir       <= nxt_ir;
            pc       <= nxt_pc;
            run_prev <= run_btn;
            mem_req  <= (nxt_state == FETCH);
            imm_oe   <= (nxt_state == LOAD);
            alu_oe   <= (nxt_state == ALU_OUT);
            alu_a_we <= (nxt_state == ALU_IN);
            alu_b_we <= (nxt_state == ALU_EXEC);
            mem_we   <= (nxt_state == STORE);
            alu_op   <= (nxt_state == ALU_EXEC) ? nxt_func : '0;
            oe_en    <= (nxt_state == STORE) || (nxt_state == MOVE) ||
                        (nxt_state == ALU_IN) || (nxt_state == ALU_EXEC);
            oe_addr  <= ((nxt_state == MOVE) || (nxt_state == ALU_IN)) ? nxt_src : nxt_dst;
            we_en    <= (nxt_state == LOAD) || (nxt_state == MOVE) || (nxt_state == ALU_OUT);
            we_addr  <= nxt_dst;
        end
    end

    reg_sel_decoder #(.RA_W(RA_W)) u_oe_dec (
        .addr   (oe_addr),
        .en     (oe_en),
        .onehot (reg_oe)
    );

    reg_sel_decoder #(.RA_W(RA_W)) u_we_dec (
        .addr   (we_addr),
        .en     (we_en),
        .onehot (reg_we)
    );

    assign instr_bus = ir[2*RA_W-1:0];
    assign busy      = (state != IDLE);
    assign paused    = (state == PAUSE);
    assign regs_clr  = clr;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed testbench for cpu_control_unit: user/run modes, wait states,
// step mode, end of program and asynchronous reset.
module tb_cpu_control_unit;

    logic       clk;
    logic       clr;
    logic       user_btn;
    logic       run_btn;
    logic       step_mode;
    logic [7:0] instr_user;
    logic [7:0] instr_mem;
    logic       auto_ack;
    logic       man_ack;

    logic       mem_ack;
    logic       mem_req;
    logic [9:0] pc;
    logic [1:0] alu_op;
    logic [3:0] reg_oe;
    logic [3:0] reg_we;
    logic       alu_a_we, alu_b_we, alu_oe, imm_oe, mem_we;
    logic [3:0] instr_bus;
    logic       busy, paused, regs_clr;

    logic       e_mem_ack;
    logic       e_mem_req;
    logic [9:0] e_pc;
    logic [1:0] e_alu_op;
    logic [3:0] e_reg_oe;
    logic [3:0] e_reg_we;
    logic       e_alu_a_we, e_alu_b_we, e_alu_oe, e_imm_oe, e_mem_we;
    logic [3:0] e_instr_bus;
    logic       e_busy, e_paused, e_regs_clr;

    logic [15:0] ctl;

    int n_checks;
    int n_fail;

    // Packed control snapshot: {mem_req, imm_oe, alu_oe, alu_a_we, alu_b_we, mem_we, alu_op, reg_oe, reg_we}
    assign ctl       = {mem_req, imm_oe, alu_oe, alu_a_we, alu_b_we, mem_we, alu_op, reg_oe, reg_we};
    assign mem_ack   = auto_ack ? mem_req   : man_ack;
    assign e_mem_ack = auto_ack ? e_mem_req : man_ack;

    cpu_control_unit dut (
        .clk        (clk),
        .clr        (clr),
        .user_btn   (user_btn),
        .run_btn    (run_btn),
        .step_mode  (step_mode),
        .instr_user (instr_user),
        .instr_mem  (instr_mem),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .pc         (pc),
        .alu_op     (alu_op),
        .reg_oe     (reg_oe),
        .reg_we     (reg_we),
        .alu_a_we   (alu_a_we),
        .alu_b_we   (alu_b_we),
        .alu_oe     (alu_oe),
        .imm_oe     (imm_oe),
        .mem_we     (mem_we),
        .instr_bus  (instr_bus),
        .busy       (busy),
        .paused     (paused),
        .regs_clr   (regs_clr)
    );

    cpu_control_unit #(.PROG_END(10'd3)) dut_end (
        .clk        (clk),
        .clr        (clr),
        .user_btn   (user_btn),
        .run_btn    (run_btn),
        .step_mode  (step_mode),
        .instr_user (instr_user),
        .instr_mem  (instr_mem),
        .mem_ack    (e_mem_ack),
        .mem_req    (e_mem_req),
        .pc         (e_pc),
        .alu_op     (e_alu_op),
        .reg_oe     (e_reg_oe),
        .reg_we     (e_reg_we),
        .alu_a_we   (e_alu_a_we),
        .alu_b_we   (e_alu_b_we),
        .alu_oe     (e_alu_oe),
        .imm_oe     (e_imm_oe),
        .mem_we     (e_mem_we),
        .instr_bus  (e_instr_bus),
        .busy       (e_busy),
        .paused     (e_paused),
        .regs_clr   (e_regs_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        clr       = 1'b1;
        user_btn  = 1'b0;
        run_btn   = 1'b0;
        step_mode = 1'b0;
        auto_ack  = 1'b0;
        man_ack   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        clr = 1'b1;
        @(negedge clk);
        n_checks++; if (ctl !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_ctl: got %h want %h", ctl, 16'h0000); end
        n_checks++; if (pc !== 10'h000) begin n_fail++; $display("[TB] FAIL reset_pc: got %h want %h", pc, 10'h000); end
        n_checks++; if ({busy, paused, regs_clr} !== 3'b001) begin n_fail++; $display("[TB] FAIL reset_status: got %b want %b", {busy, paused, regs_clr}, 3'b001); end
        n_checks++; if (instr_bus !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_instr_bus: got %h want %h", instr_bus, 4'h0); end
        clr = 1'b0;
        @(negedge clk);
        n_checks++; if ({busy, regs_clr} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_release: got %b want %b", {busy, regs_clr}, 2'b00); end
    endtask

    task automatic test_user_load();
        do_reset();
        instr_user = 8'b00_10_0111;
        user_btn   = 1'b1;
        @(negedge clk);
        n_checks++; if ({busy, pc} !== {1'b1, 10'h3FF}) begin n_fail++; $display("[TB] FAIL user_load_arm: got %b/%h want 1/3ff", busy, pc); end
        user_btn = 1'b0;
        @(negedge clk);
        n_checks++; if (ctl !== 16'h0000) begin n_fail++; $display("[TB] FAIL user_load_latch_ctl: got %h want %h", ctl, 16'h0000); end
        @(negedge clk);
        n_checks++; if (ctl !== 16'h4004) begin n_fail++; $display("[TB] FAIL user_load_ctl: got %h want %h", ctl, 16'h4004); end
        n_checks++; if (instr_bus !== 4'b0111) begin n_fail++; $display("[TB] FAIL user_load_bus: got %b want %b", instr_bus, 4'b0111); end
        @(negedge clk);
        n_checks++; if (ctl !== 16'h0000) begin n_fail++; $display("[TB] FAIL user_load_retire_ctl: got %h want %h", ctl, 16'h0000); end
        @(negedge clk);
        n_checks++; if ({busy, pc} !== {1'b0, 10'h3FF}) begin n_fail++; $display("[TB] FAIL user_load_idle: got %b/%h want 0/3ff", busy, pc); end
    endtask

    task automatic test_user_store_tie();
        do_reset();
        instr_user = 8'b01_11_0101;
        user_btn   = 1'b1;
        run_btn    = 1'b1;
        @(negedge clk);
        n_checks++; if (pc !== 10'h3FF) begin n_fail++; $display("[TB] FAIL tie_user_wins: got pc %h want %h", pc, 10'h3FF); end
        user_btn = 1'b0;
        run_btn  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (ctl !== 16'h0480) begin n_fail++; $display("[TB] FAIL user_store_ctl: got %h want %h", ctl, 16'h0480); end
        n_checks++; if (instr_bus !== 4'b0101) begin n_fail++; $display("[TB] FAIL user_store_bus: got %b want %b", instr_bus, 4'b0101); end
        @(negedge clk);
        @(negedge clk);
        n_checks++; if ({busy, ctl} !== {1'b0, 16'h0000}) begin n_fail++; $display("[TB] FAIL user_store_idle: got %b/%h want 0/0000", busy, ctl); end
    endtask

    task automatic test_run_alu();
        do_reset();
        auto_ack  = 1'b1;
        instr_mem = 8'b11_01_10_11;
        run_btn   = 1'b1;
        @(negedge clk);
        n_checks++; if ({busy, pc} !== {1'b1, 10'h000}) begin n_fail++; $display("[TB] FAIL run_arm: got %b/%h want 1/000", busy, pc); end
        run_btn = 1'b0;
        @(negedge clk);
        n_checks++; if (ctl !== 16'h8000) begin n_fail++; $display("[TB] FAIL run_fetch_ctl: got %h want %h", ctl, 16'h8000); end
        @(negedge clk);
        n_checks++; if (ctl !== 16'h1040) begin n_fail++; $display("[TB] FAIL alu_in_ctl: got %h want %h", ctl, 16'h1040); end
        @(negedge clk);
        n_checks++; if (ctl !== 16'h0B20) begin n_fail++; $display("[TB] FAIL alu_exec_ctl: got %h want %h", ctl, 16'h0B20); end
        @(negedge clk);
        n_checks++; if (ctl !== 16'h2002) begin n_fail++; $display("[TB] FAIL alu_out_ctl: got %h want %h", ctl, 16'h2002); end
        @(negedge clk);
        n_checks++; if ({ctl, pc} !== {16'h0000, 10'h000}) begin n_fail++; $display("[TB] FAIL alu_retire: got %h/%h want 0000/000", ctl, pc); end
        @(negedge clk);
        n_checks++; if ({ctl, pc} !== {16'h8000, 10'h001}) begin n_fail++; $display("[TB] FAIL alu_next_fetch: got %h/%h want 8000/001", ctl, pc); end
    endtask

    task automatic test_wait_states();
        do_reset();
        instr_mem = 8'hFF;
        run_btn   = 1'b1;
        @(negedge clk);
        run_btn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (ctl !== 16'h8000) begin n_fail++; $display("[TB] FAIL wait_fetch_%0d: got %h want %h", i, ctl, 16'h8000); end
        end
        instr_mem = 8'b10_11_01_00;
        man_ack   = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        n_checks++; if (ctl !== 16'h0028) begin n_fail++; $display("[TB] FAIL wait_move_ctl: got %h want %h", ctl, 16'h0028); end
        n_checks++; if (instr_bus !== 4'b0100) begin n_fail++; $display("[TB] FAIL wait_latched: got %b want %b", instr_bus, 4'b0100); end
        @(negedge clk);
        n_checks++; if (ctl !== 16'h0000) begin n_fail++; $display("[TB] FAIL wait_retire_ctl: got %h want %h", ctl, 16'h0000); end
        @(negedge clk);
        n_checks++; if ({ctl, pc} !== {16'h8000, 10'h001}) begin n_fail++; $display("[TB] FAIL wait_refetch: got %h/%h want 8000/001", ctl, pc); end
    endtask

    task automatic test_step_mode();
        do_reset();
        step_mode = 1'b1;
        auto_ack  = 1'b1;
        instr_mem = 8'b10_00_11_00;
        run_btn   = 1'b1;
        @(negedge clk);
        run_btn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (ctl !== 16'h0081) begin n_fail++; $display("[TB] FAIL step_move_ctl: got %h want %h", ctl, 16'h0081); end
        @(negedge clk);
        @(negedge clk);
        n_checks++; if ({paused, pc} !== {1'b1, 10'h001}) begin n_fail++; $display("[TB] FAIL step_pause1: got %b/%h want 1/001", paused, pc); end
        repeat (3) @(negedge clk);
        n_checks++; if ({paused, ctl} !== {1'b1, 16'h0000}) begin n_fail++; $display("[TB] FAIL step_hold: got %b/%h want 1/0000", paused, ctl); end
        user_btn = 1'b1;
        @(negedge clk);
        user_btn = 1'b0;
        n_checks++; if ({paused, pc} !== {1'b1, 10'h001}) begin n_fail++; $display("[TB] FAIL step_user_ignored: got %b/%h want 1/001", paused, pc); end
        run_btn = 1'b1;
        @(negedge clk);
        n_checks++; if (ctl !== 16'h8000) begin n_fail++; $display("[TB] FAIL step_edge_fetch: got %h want %h", ctl, 16'h8000); end
        repeat (6) @(negedge clk);
        n_checks++; if ({paused, pc} !== {1'b1, 10'h002}) begin n_fail++; $display("[TB] FAIL step_held_once: got %b/%h want 1/002", paused, pc); end
        run_btn = 1'b0;
        @(negedge clk);
        run_btn = 1'b1;
        @(negedge clk);
        run_btn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if ({paused, pc} !== {1'b1, 10'h003}) begin n_fail++; $display("[TB] FAIL step_pause3: got %b/%h want 1/003", paused, pc); end
    endtask

    task automatic test_end_of_program();
        int cycles;
        do_reset();
        auto_ack  = 1'b1;
        instr_mem = 8'b10_00_11_00;
        run_btn   = 1'b1;
        @(negedge clk);
        run_btn = 1'b0;
        cycles  = 0;
        @(negedge clk);
        while (e_busy && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
        n_checks++; if (cycles !== 12) begin n_fail++; $display("[TB] FAIL end_cycles: got %0d want %0d", cycles, 12); end
        n_checks++; if ({e_busy, e_pc} !== {1'b0, 10'h003}) begin n_fail++; $display("[TB] FAIL end_idle: got %b/%h want 0/003", e_busy, e_pc); end
        repeat (3) @(negedge clk);
        n_checks++; if ({e_busy, e_pc, e_mem_req} !== {1'b0, 10'h003, 1'b0}) begin n_fail++; $display("[TB] FAIL end_no_wrap: got %b/%h/%b want 0/003/0", e_busy, e_pc, e_mem_req); end
    endtask

    task automatic test_async_reset();
        do_reset();
        auto_ack  = 1'b1;
        instr_mem = 8'b11_01_10_11;
        run_btn   = 1'b1;
        @(negedge clk);
        run_btn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ctl !== 16'h0B20) begin n_fail++; $display("[TB] FAIL areset_pre: got %h want %h", ctl, 16'h0B20); end
        #2 clr = 1'b1;
        #1;
        n_checks++; if (ctl !== 16'h0000) begin n_fail++; $display("[TB] FAIL areset_ctl: got %h want %h", ctl, 16'h0000); end
        n_checks++; if ({busy, pc, regs_clr} !== {1'b0, 10'h000, 1'b1}) begin n_fail++; $display("[TB] FAIL areset_state: got %b/%h/%b want 0/000/1", busy, pc, regs_clr); end
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        clr        = 1'b1;
        user_btn   = 1'b0;
        run_btn    = 1'b0;
        step_mode  = 1'b0;
        auto_ack   = 1'b0;
        man_ack    = 1'b0;
        instr_user = 8'h00;
        instr_mem  = 8'h00;
        test_reset();
        test_user_load();
        test_user_store_tie();
        test_run_alu();
        test_wait_states();
        test_step_mode();
        test_end_of_program();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
